cksum_multi: RTL



---
 rtl/cksum_pkg.sv | 25 ++
 rtl/cksum_lane_sum.sv | 50 +++++
 rtl/cksum_multi.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cksum_pkg.sv
// Shared types, defaults and the byte-lane mask helper for the RFC 1071 checksum engine.
package cksum_pkg;

    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned PTR_W     = 16;

    typedef enum logic {
        CK_GENERATE = 1'b0,
        CK_VERIFY   = 1'b1
    } ck_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUM,
        ST_FOLD,
        ST_FINAL
    } ck_state_e;

    // A byte contributes only when it lies before the field end.
    function automatic logic byte_live(input logic [PTR_W-1:0] addr,
                                       input logic [PTR_W-1:0] end_addr);
        return addr < end_addr;
    endfunction

endpackage

// File: rtl/cksum_lane_sum.sv
// Combinational sum of LANES masked big-endian 16-bit words starting at base.
module cksum_lane_sum
    import cksum_pkg::*;
#(
    parameter int unsigned HDR_MAX_LEN = 128,
    parameter int unsigned LANES       = 4,
    parameter int unsigned ACC_W       = ACC_W_DEF
) (
    input  logic [HDR_MAX_LEN-1:0][7:0] hdr,
    input  logic [PTR_W-1:0]            base,
    input  logic [PTR_W-1:0]            end_addr,
    input  logic [PTR_W-1:0]            skip_addr,
    input  logic                        skip_en,
    output logic [ACC_W-1:0]            sum
);

    localparam int unsigned       IDX_W = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(HDR_MAX_LEN - 1);

    logic [15:0] word [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PTR_W-1:0] hi_addr;
        logic [PTR_W-1:0] lo_addr;
        logic [IDX_W-1:0] hi_idx;
        logic [IDX_W-1:0] lo_idx;
        logic [7:0]       hi_byte;
        logic [7:0]       lo_byte;

        assign hi_addr = base + PTR_W'(2 * k);
        assign lo_addr = hi_addr + PTR_W'(1);

        // Clamp so the array read stays in range; the live mask zeroes it anyway.
        assign hi_idx = (hi_addr > LAST) ? IDX_W'(LAST) : IDX_W'(hi_addr);
        assign lo_idx = (lo_addr > LAST) ? IDX_W'(LAST) : IDX_W'(lo_addr);

        assign hi_byte = byte_live(hi_addr, end_addr) ? hdr[hi_idx] : 8'h00;
        assign lo_byte = byte_live(lo_addr, end_addr) ? hdr[lo_idx] : 8'h00;

        assign word[k] = (skip_en && (hi_addr == skip_addr)) ? 16'h0000 : {hi_byte, lo_byte};
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + ACC_W'(word[k]);
        end
    end

endmodule

// File: rtl/cksum_multi.sv
// Multi-lane ones'-complement checksum engine: generate (with field masking) or verify.
module cksum_multi
    import cksum_pkg::*;
#(
    parameter  int unsigned HDR_MAX_LEN = 128,
    parameter  int unsigned LANES       = 4,
    parameter  int unsigned ACC_W       = ACC_W_DEF,
    localparam int unsigned ADDR_W      = $clog2(HDR_MAX_LEN) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        mode_i,
    input  logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_i,
    input  logic [ADDR_W-1:0]           field_start_i,
    input  logic [ADDR_W-1:0]           field_len_i,
    input  logic                        skip_en_i,
    input  logic [ADDR_W-1:0]           skip_off_i,
    output logic                        busy_o,
    output logic [15:0]                 cksum_val_o,
    output logic                        cksum_ok_o,
    output logic                        err_o,
    output logic                        cksum_ready_o
);

    localparam logic [PTR_W-1:0] STEP = PTR_W'(2 * LANES);

    ck_state_e        state_q, state_d;
    ck_mode_e         mode_q, mode_d;
    logic [PTR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0] end_q, end_d;
    logic [PTR_W-1:0] skip_addr_q, skip_addr_d;
    logic             skip_en_q, skip_en_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic             busy_d;
    logic [15:0]      val_d;
    logic             ok_d;
    logic             err_d;
    logic             ready_d;

    logic [ACC_W-1:0] lane_sum;
    logic [ACC_W-1:0] fold_sum;
    logic [PTR_W-1:0] start_w;
    logic [PTR_W-1:0] req_end;
    ck_mode_e         mode_in;
    logic             bad_req;

    cksum_lane_sum #(
        .HDR_MAX_LEN (HDR_MAX_LEN),
        .LANES       (LANES),
        .ACC_W       (ACC_W)
    ) u_lane_sum (
        .hdr       (pkt_hdr_i),
        .base      (addr_q),
        .end_addr  (end_q),
        .skip_addr (skip_addr_q),
        .skip_en   (skip_en_q),
        .sum       (lane_sum)
    );

    assign fold_sum = ACC_W'(acc_q[ACC_W-1:16]) + ACC_W'(acc_q[15:0]);
    assign start_w  = PTR_W'(field_start_i);
    assign req_end  = start_w + PTR_W'(field_len_i);
    assign mode_in  = ck_mode_e'(mode_i);
    assign bad_req  = (req_end > PTR_W'(HDR_MAX_LEN)) ||
                      (skip_en_i && skip_off_i[0] && (mode_in == CK_GENERATE));

    // Next-state, datapath and output-register inputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        end_d       = end_q;
        skip_addr_d = skip_addr_q;
        skip_en_d   = skip_en_q;
        acc_d       = acc_q;
        val_d       = cksum_val_o;
        ok_d        = cksum_ok_o;
        err_d       = err_o;
        ready_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (bad_req) begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        val_d   = 16'h0000;
                        ok_d    = 1'b0;
                    end else begin
                        state_d     = ST_SUM;
                        mode_d      = mode_in;
                        addr_d      = start_w;
                        end_d       = req_end;
                        skip_addr_d = start_w + PTR_W'(skip_off_i);
                        skip_en_d   = skip_en_i && (mode_in == CK_GENERATE);
                        acc_d       = '0;
                    end
                end
            end
            ST_SUM: begin
                acc_d  = acc_q + lane_sum;
                addr_d = addr_q + STEP;
                if (addr_q + STEP >= end_q) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                acc_d   = fold_sum;
                state_d = ST_FINAL;
            end
            ST_FINAL: begin
                val_d   = ~fold_sum[15:0];
                ok_d    = (mode_q == CK_VERIFY) && (fold_sum[15:0] == 16'hFFFF);
                err_d   = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= CK_GENERATE;
            addr_q        <= '0;
            end_q         <= '0;
            skip_addr_q   <= '0;
            skip_en_q     <= 1'b0;
            acc_q         <= '0;
            busy_o        <= 1'b0;
            cksum_val_o   <= 16'h0000;
            cksum_ok_o    <= 1'b0;
            err_o         <= 1'b0;
            cksum_ready_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            addr_q        <= addr_d;
            end_q         <= end_d;
            skip_addr_q   <= skip_addr_d;
            skip_en_q     <= skip_en_d;
            acc_q         <= acc_d;
            busy_o        <= busy_d;
            cksum_val_o   <= val_d;
            cksum_ok_o    <= ok_d;
            err_o         <= err_d;
            cksum_ready_o <= ready_d;
        end
    end

endmodule
